// File: rtl/video_io.sv
// Vector-06C video I/O register stage: 8255 PPI ports 00h-03h, palette write
// strobe generation and the 50 Hz frame interrupt request.
module video_io #(
  parameter int PAL_HOLD    = 16,
  parameter int INT_TIMEOUT = 1536
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_12mp,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_dout,
  input  logic       retrace,
  input  logic       int_ack,
  output logic [7:0] scroll,
  output logic [3:0] border,
  output logic       mode512,
  output logic [7:0] port_c,
  output logic [7:0] pal_data,
  output logic       pal_we,
  output logic       int_req
);

  localparam logic [1:0]  ST_IDLE  = 2'b00;
  localparam logic [1:0]  ST_GAP   = 2'b01;
  localparam logic [1:0]  ST_HOLD  = 2'b10;
  localparam logic [7:0]  PAL_LOAD = 8'(PAL_HOLD);
  localparam logic [15:0] INT_LOAD = 16'(INT_TIMEOUT);

  logic [7:0]  reg_a;
  logic [7:0]  reg_b;
  logic [7:0]  reg_c;
  logic [7:0]  ctrl;
  logic [1:0]  pal_state;
  logic [7:0]  pal_cnt;
  logic [15:0] int_cnt;
  logic        retrace_p1;
  logic        ppi_sel;
  logic        ppi_wr;
  logic        pal_wr;
  logic        retrace_rise;

  assign ppi_sel      = (io_addr[7:2] == 6'b000000);
  assign ppi_wr       = io_wr && ppi_sel;
  assign pal_wr       = io_wr && (io_addr[7:2] == 6'b000011);
  assign retrace_rise = retrace && !retrace_p1;

  assign scroll  = reg_a;
  assign border  = reg_b[3:0];
  assign mode512 = reg_b[4];
  assign port_c  = reg_c;
  // HOLD is encoded so that pal_we is a flop bit rather than a decode.
  assign pal_we  = pal_state[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      reg_a <= 8'hFF;
      reg_b <= 8'h00;
      reg_c <= 8'h00;
      ctrl  <= 8'h9B;
    end else if (ppi_wr) begin
      case (io_addr[1:0])
        2'd3: reg_a <= io_din;
        2'd2: reg_b <= io_din;
        2'd1: reg_c <= io_din;
        default: begin
          if (io_din[7]) begin
            ctrl  <= io_din;
            reg_a <= 8'h00;
            reg_b <= 8'h00;
            reg_c <= 8'h00;
          end else begin
            reg_c[io_din[3:1]] <= io_din[0];
          end
        end
      endcase
    end
  end

  // Reads sample the pre-write register values, so a same-cycle write is not seen.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      io_dout <= 8'h00;
    end else if (io_rd) begin
      if (ppi_sel) begin
        case (io_addr[1:0])
          2'd0:    io_dout <= ctrl;
          2'd1:    io_dout <= reg_c;
          2'd2:    io_dout <= reg_b;
          default: io_dout <= reg_a;
        endcase
      end else begin
        io_dout <= 8'hFF;
      end
    end
  end

  // A write during HOLD detours through GAP so the display sees a new rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pal_state <= ST_IDLE;
      pal_cnt   <= 8'h00;
      pal_data  <= 8'h00;
    end else begin
      if (pal_wr) begin
        pal_data <= io_din;
        pal_cnt  <= PAL_LOAD;
      end
      case (pal_state)
        ST_IDLE: if (pal_wr) pal_state <= ST_HOLD;
        ST_GAP:  pal_state <= ST_HOLD;
        ST_HOLD: begin
          if (pal_wr) begin
            pal_state <= ST_GAP;
          end else if (ce_12mp) begin
            pal_cnt <= pal_cnt - 8'd1;
            if (pal_cnt <= 8'd1) pal_state <= ST_IDLE;
          end
        end
        default: pal_state <= ST_IDLE;
      endcase
    end
  end

  // retrace_p1 resets high so a retrace already high at reset release is not an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      retrace_p1 <= 1'b1;
      int_req    <= 1'b0;
      int_cnt    <= 16'h0000;
    end else begin
      retrace_p1 <= retrace;
      if (retrace_rise) begin
        int_req <= 1'b1;
        int_cnt <= INT_LOAD;
      end else if (int_req) begin
        if (int_ack) begin
          int_req <= 1'b0;
        end else if (ce_12mp) begin
          int_cnt <= int_cnt - 16'd1;
          if (int_cnt <= 16'd1) int_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_io.sv
// Directed bench for video_io: PPI registers, reads, palette pulse and frame interrupt.
module tb_video_io;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce_12mp;
  logic [7:0] io_addr;
  logic [7:0] io_din;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_dout;
  logic       retrace;
  logic       int_ack;
  logic [7:0] scroll;
  logic [3:0] border;
  logic       mode512;
  logic [7:0] port_c;
  logic [7:0] pal_data;
  logic       pal_we;
  logic       int_req;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  video_io #(.PAL_HOLD(16), .INT_TIMEOUT(1536)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce_12mp (ce_12mp),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_dout (io_dout),
    .retrace (retrace),
    .int_ack (int_ack),
    .scroll  (scroll),
    .border  (border),
    .mode512 (mode512),
    .port_c  (port_c),
    .pal_data(pal_data),
    .pal_we  (pal_we),
    .int_req (int_req)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // ce_12mp is high on every third cycle.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
    ce_12mp = (cyc % 3 == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr = a;
    io_din  = d;
    io_wr   = 1'b1;
    tick();
    io_wr   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    io_addr = a;
    io_rd   = 1'b1;
    tick();
    io_rd   = 1'b0;
  endtask

  // Counts ce_12mp ticks applied while pal_we is high, until it drops.
  task automatic pal_ticks(output int n);
    int  guard;
    bit  c;
    n = 0;
    guard = 0;
    while (pal_we === 1'b1 && guard < 2000) begin
      c = ce_12mp;
      tick();
      if (c) n++;
      guard++;
    end
    if (guard >= 2000) n = -1;
  endtask

  task automatic int_ticks(output int n);
    int  guard;
    bit  c;
    n = 0;
    guard = 0;
    while (int_req === 1'b1 && guard < 10000) begin
      c = ce_12mp;
      tick();
      if (c) n++;
      guard++;
    end
    if (guard >= 10000) n = -1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    ce_12mp = 1'b0;
    io_addr = 8'h00;
    io_din  = 8'h00;
    io_wr   = 1'b0;
    io_rd   = 1'b0;
    retrace = 1'b1;
    int_ack = 1'b0;

    repeat (3) tick();
    chk("rst_scroll", 32'(scroll), 32'hFF);
    chk("rst_pal_we", 32'(pal_we), 32'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rel_scroll", 32'(scroll), 32'hFF);
    chk("rel_border", 32'(border), 32'h0);
    chk("rel_mode512", 32'(mode512), 32'h0);
    chk("rel_port_c", 32'(port_c), 32'h00);
    chk("rel_int_req", 32'(int_req), 32'h0);
    chk("rel_io_dout", 32'(io_dout), 32'h00);
    chk("rel_pal_data", 32'(pal_data), 32'h00);
    rd(8'h00);
    chk("rd_ctrl_rst", 32'(io_dout), 32'h9B);
    rd(8'h03);
    chk("rd_a_rst", 32'(io_dout), 32'hFF);

    wr(8'h02, 8'h12);
    chk("b_border", 32'(border), 32'h2);
    chk("b_mode512", 32'(mode512), 32'h1);
    rd(8'h02);
    chk("rd_b", 32'(io_dout), 32'h12);

    wr(8'h03, 8'h55);
    chk("a_scroll", 32'(scroll), 32'h55);
    wr(8'h00, 8'h80);
    chk("mode_scroll", 32'(scroll), 32'h00);
    chk("mode_port_c", 32'(port_c), 32'h00);
    chk("mode_border", 32'(border), 32'h0);
    rd(8'h00);
    chk("rd_ctrl", 32'(io_dout), 32'h80);
    wr(8'h00, 8'h0B);
    chk("bsr_set5", 32'(port_c), 32'h20);
    wr(8'h00, 8'h0A);
    chk("bsr_clr5", 32'(port_c), 32'h00);
    rd(8'h00);
    chk("rd_ctrl_bsr", 32'(io_dout), 32'h80);
    wr(8'h01, 8'hA5);
    chk("c_port_c", 32'(port_c), 32'hA5);
    rd(8'h01);
    chk("rd_c", 32'(io_dout), 32'hA5);

    io_addr = 8'h03;
    io_din  = 8'h77;
    io_wr   = 1'b1;
    io_rd   = 1'b1;
    tick();
    io_wr   = 1'b0;
    io_rd   = 1'b0;
    chk("rdwr_old", 32'(io_dout), 32'h00);
    chk("rdwr_new", 32'(scroll), 32'h77);

    rd(8'h05);
    chk("rd_unmapped", 32'(io_dout), 32'hFF);
    wr(8'h05, 8'hAA);
    chk("wr5_scroll", 32'(scroll), 32'h77);
    chk("wr5_border", 32'(border), 32'h0);
    chk("wr5_port_c", 32'(port_c), 32'hA5);
    chk("wr5_pal_we", 32'(pal_we), 32'h0);
    chk("wr5_pal_data", 32'(pal_data), 32'h00);

    wr(8'h0C, 8'h3C);
    chk("pal1_data", 32'(pal_data), 32'h3C);
    chk("pal1_we", 32'(pal_we), 32'h1);
    pal_ticks(n);
    chk("pal1_ticks", 32'(n), 32'd16);
    tick();
    chk("pal1_low", 32'(pal_we), 32'h0);

    wr(8'h0F, 8'h0F);
    chk("pal2_data", 32'(pal_data), 32'h0F);
    chk("pal2_we", 32'(pal_we), 32'h1);
    pal_ticks(n);
    chk("pal2_ticks", 32'(n), 32'd16);

    tick();
    wr(8'h0D, 8'h5A);
    chk("pal3_we", 32'(pal_we), 32'h1);
    n = 0;
    for (int g = 0; g < 100 && n < 5; g++) begin
      bit c;
      c = ce_12mp;
      tick();
      if (c) n++;
    end
    chk("pal3_mid", 32'(pal_we), 32'h1);
    wr(8'h0E, 8'hC3);
    chk("restart_gap", 32'(pal_we), 32'h0);
    chk("restart_data", 32'(pal_data), 32'hC3);
    tick();
    chk("restart_high", 32'(pal_we), 32'h1);
    pal_ticks(n);
    chk("restart_ticks", 32'(n), 32'd16);

    retrace = 1'b0;
    tick();
    chk("int_idle", 32'(int_req), 32'h0);
    retrace = 1'b1;
    tick();
    chk("int_set", 32'(int_req), 32'h1);
    repeat (9) tick();
    chk("int_held", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("int_acked", 32'(int_req), 32'h0);

    retrace = 1'b0;
    tick();
    retrace = 1'b1;
    tick();
    chk("int2_set", 32'(int_req), 32'h1);
    int_ticks(n);
    chk("int_timeout", 32'(n), 32'd1536);
    chk("int_selfclr", 32'(int_req), 32'h0);

    retrace = 1'b0;
    tick();
    retrace = 1'b1;
    tick();
    chk("int3_set", 32'(int_req), 32'h1);
    retrace = 1'b0;
    tick();
    retrace = 1'b1;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("int_set_wins", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("int3_acked", 32'(int_req), 32'h0);

    retrace = 1'b0;
    tick();
    retrace = 1'b1;
    tick();
    wr(8'h0C, 8'h11);
    chk("pre_rst_we", 32'(pal_we), 32'h1);
    chk("pre_rst_int", 32'(int_req), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_we", 32'(pal_we), 32'h0);
    chk("async_int", 32'(int_req), 32'h0);
    chk("async_scroll", 32'(scroll), 32'hFF);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_we", 32'(pal_we), 32'h0);
    chk("post_rst_int", 32'(int_req), 32'h0);
    chk("post_rst_data", 32'(pal_data), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
